// File: rtl/fire_chk.sv
// fire_chk -- serial syndrome checker for the (64,40) Fire code.
//
// Accepts one 64-bit codeword (40 data bits over 24 parity bits), divides it
// by g(x) one coefficient per cycle, highest power first, and presents the
// 40 data bits, the 24-bit remainder and an error flag. A saturating 16-bit
// counter tallies codewords whose remainder is non-zero.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready codeword handshake; cw_in[i] = coefficient of x^i
//   out_valid/out_ready result handshake
//   data_out          cw[63:24] of the word under check
//   syndrome, err     remainder r(x) mod g(x) and its non-zero flag
//   err_cnt           saturating count of results with err=1
//   busy              high while the word is being shifted through
module fire_chk #(
    parameter int          N     = 64,
    parameter int          K     = 40,
    parameter int          R     = N - K,
    parameter logic [23:0] GPOLY = 24'h088211
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] cw_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] data_out,
    output logic [R-1:0] syndrome,
    output logic         err,
    output logic [15:0]  err_cnt,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [R-1:0]   syn_q, syn_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [K-1:0]   data_q, data_d;
    logic [R-1:0]   synd_q, synd_d;
    logic           err_q, err_d;
    logic [15:0]    err_cnt_q, err_cnt_d;
    logic [R-1:0]   syn_next;

    // One LFSR division step: bring in the next codeword coefficient and
    // subtract g(x) whenever the x^24 term would overflow the remainder.
    assign syn_next = {syn_q[R-2:0], shreg_q[N-1]} ^ (syn_q[R-1] ? GPOLY : '0);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        syn_d     = syn_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        synd_d    = synd_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = cw_in;
                    syn_d   = '0;
                    cnt_d   = '0;
                    data_d  = cw_in[N-1:R];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                syn_d   = syn_next;
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + 7'd1;
                if (cnt_q == 7'(N - 1)) begin
                    // Last coefficient: publish the result on the same edge
                    // so the counter moves exactly once per codeword.
                    state_d = HOLD;
                    synd_d  = syn_next;
                    err_d   = |syn_next;
                    if (|syn_next && err_cnt_q != 16'hFFFF)
                        err_cnt_d = err_cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            syn_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            synd_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            syn_q     <= syn_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            synd_q    <= synd_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == SHIFT);
    assign data_out  = data_q;
    assign syndrome  = synd_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_fire_chk.sv
module tb_fire_chk;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [63:0] cw_in;
    logic        out_valid, out_ready;
    logic [39:0] data_out;
    logic [23:0] syndrome;
    logic        err;
    logic [15:0] err_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // reference model state: expected result of the word most recently accepted
    logic [39:0] exp_data = '0;
    logic [23:0] exp_syn  = '0;
    logic        exp_err  = 1'b0;
    logic [15:0] exp_cnt  = '0;

    always #5 clk = ~clk;

    fire_chk dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .cw_in(cw_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .syndrome(syndrome), .err(err),
        .err_cnt(err_cnt), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Polynomial long division over GF(2): remainder of cw(x) / g(x).
    function automatic logic [23:0] fire_rem(input logic [63:0] cw);
        logic [63:0] r;
        logic [63:0] g;
        r = cw;
        g = 64'h0000_0000_0108_8211;
        for (int i = 63; i >= 24; i--)
            if (r[i]) r = r ^ (g << (i - 24));
        return r[23:0];
    endfunction

    function automatic logic [63:0] encode(input logic [39:0] m);
        logic [63:0] cw;
        cw = {m, 24'h0};
        cw[23:0] = fire_rem(cw);
        return cw;
    endfunction

    function automatic void model_accept(input logic [63:0] cw);
        exp_data = cw[63:24];
        exp_syn  = fire_rem(cw);
        exp_err  = |exp_syn;
        if (exp_err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endfunction

    // Compare process: every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("data_out", 64'(data_out), 64'(exp_data));
            chk("syndrome", 64'(syndrome), 64'(exp_syn));
            chk("err", 64'(err), 64'(exp_err));
            chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
            chk("in_ready_hold", 64'(in_ready), 64'd0);
        end
    end

    // Offer cw, wait (bounded) for acceptance; returns #1 after the acceptance edge.
    task automatic accept(input logic [63:0] cw);
        int n;
        @(negedge clk);
        cw_in = cw;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_accept(cw);
    endtask

    // Called #1 after the acceptance edge; measures latency, then holds the
    // result for `hold` extra cycles before completing the handshake.
    task automatic wait_result(input int hold);
        int lat;
        lat = 0;
        if (hold > 0) out_ready = 1'b0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        chk("latency", 64'(lat), 64'd64);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("out_valid_drop", 64'(out_valid), 64'd0);
    endtask

    task automatic run_word(input logic [63:0] cw, input int hold);
        accept(cw);
        wait_result(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; cw_in = '0; out_ready = 1'b1;
        #23;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_syndrome", 64'(syndrome), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge clk); rst = 1'b0;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

        // model pins
        chk("model_x24", 64'(fire_rem(64'h1 << 24)), 64'h088211);
        chk("model_g", 64'(fire_rem({40'h1, 24'h088211})), 64'h0);
        chk("model_x0", 64'(fire_rem(64'h1)), 64'h1);

        run_word(64'h0, 0);
        chk("zero_syn", 64'(syndrome), 64'h0);
        chk("zero_cnt", 64'(err_cnt), 64'h0);

        run_word({40'h0000000001, 24'h088211}, 0);
        chk("g_data", 64'(data_out), 64'h1);
        chk("g_err", 64'(err), 64'h0);

        run_word(64'h1, 0);
        chk("x0_syn", 64'(syndrome), 64'h000001);
        chk("x0_cnt", 64'(err_cnt), 64'h1);

        run_word(64'h1 << 24, 0);
        chk("x24_syn", 64'(syndrome), 64'h088211);
        chk("x24_cnt", 64'(err_cnt), 64'h2);

        run_word(encode(40'hA5_5A12_3456), 0);
        chk("enc_err", 64'(err), 64'h0);
        run_word(encode(40'hFF_FFFF_FFFF), 0);
        run_word(encode(40'h12_3456_789A) ^ (64'h1F << 30), 0);
        chk("burst_err", 64'(err), 64'h1);
        run_word(encode(40'h80_0000_0001) ^ 64'h8000_0000_0000_0000, 0);

        // backpressure with a second word pending during HOLD
        accept(64'hDEAD_BEEF_0000_0001);
        out_ready = 1'b0;
        begin
            int lat;
            lat = 0;
            while (lat < 200) begin
                @(posedge clk); lat++; #1;
                if (out_valid) break;
            end
            chk("bp_latency", 64'(lat), 64'd64);
        end
        cw_in = 64'h1 << 40;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ov", 64'(out_valid), 64'd0);
        chk("bp_release_busy", 64'(busy), 64'd0);
        chk("bp_release_rdy", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp_second_busy", 64'(busy), 64'd1);
        in_valid = 1'b0;
        model_accept(64'h1 << 40);
        wait_result(0);
        chk("bp_second_syn", 64'(syndrome), 64'(fire_rem(64'h1 << 40)));

        // reset in the middle of shifting
        accept(64'h1);
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ov", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(data_out), 64'd0);
        chk("mid_rst_syn", 64'(syndrome), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        chk("mid_rst_cnt", 64'(err_cnt), 64'd0);
        exp_cnt = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_result_after_rst", 64'(seen), 64'd0);
        run_word(64'h0, 0);
        chk("post_rst_clean", 64'(err), 64'd0);

        // saturation: preload just below the limit, then past it
        @(negedge clk);
        force dut.err_cnt_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.err_cnt_q;
        exp_cnt = 16'hFFFE;
        @(negedge clk);
        chk("preload", 64'(err_cnt), 64'hFFFE);
        run_word(64'h1, 0);
        chk("sat_reach", 64'(err_cnt), 64'hFFFF);
        run_word(64'h1 << 24, 0);
        chk("sat_hold", 64'(err_cnt), 64'hFFFF);
        chk("sat_err", 64'(err), 64'h1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fire_chk.md
# fire_chk

Serial syndrome checker for the (64,40) Fire code. It sits directly downstream of the 24-bit parity shift-register encoder and consumes the assembled 64-bit codeword: 40 data bits plus that encoder's 24 parity bits. It divides the codeword by g(x) one bit per cycle, returns the 40 data bits with the 24-bit syndrome and an error flag, and keeps a saturating count of failing codewords.

## Interface
- N, 64, codeword length
- K, 40, data length; R = N-K = 24 parity/syndrome bits
- GPOLY, 24'h088211, low 24 coefficients of g(x) = x^24+x^19+x^15+x^9+x^4+1 = (x^15+1)(x^9+x^4+1); bit i = coeff of x^i
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  codeword offered
- in_ready  out  1  block can accept a codeword
- cw_in  in  N  codeword; cw_in[i] = coeff of x^i; cw_in[63:24] = data (data bit K-1 at cw_in[63]); cw_in[23-j] = encoder parity output bit j
- out_valid  out  1  result available
- out_ready  in  1  downstream takes result
- data_out  out  K  cw[63:24] of the checked word
- syndrome  out  R  r(x) mod g(x), bit i = coeff of x^i
- err  out  1  syndrome != 0
- err_cnt  out  16  number of results with err=1, saturates at 16'hFFFF
- busy  out  1  state == SHIFT

## Operation
- States: IDLE, SHIFT, HOLD.
- IDLE: in_ready=1. On in_valid: latch cw_in into a 64-bit shift register, clear syn to 0, clear the 7-bit counter cnt to 0, go to SHIFT.
- SHIFT: one bit per cycle, MSB first (x^63 down to x^0). b = shreg[63]; fb = syn[23]; syn <= {syn[22:0], b} ^ (fb ? GPOLY : 0); shreg <= shreg << 1; cnt <= cnt+1. After the shift with cnt==63, go to HOLD.
- The data field is captured to data_out at acceptance and is not modified afterwards.
- HOLD entry: drive syndrome = syn and err = |syn. If err=1, increment err_cnt unless it is already 16'hFFFF. Increment exactly once per codeword.
- HOLD: out_valid=1. Outputs are stable until out_ready. On out_ready: go to IDLE.
- in_ready=0 in SHIFT and HOLD. in_valid is ignored there and no input is lost: the upstream holds it.
- A valid codeword (cw = m·x^24 + (m·x^24 mod g)) yields syndrome 0 and err 0.

## Timing
- Acceptance at edge T (IDLE, in_valid=1). Shifts occur on edges T+1..T+64. out_valid is high from just after edge T+64.
- Latency from acceptance to out_valid: 64 cycles.
- Minimum issue interval: 66 cycles (accept, 64 shifts, 1 HOLD cycle with out_ready=1, then IDLE for 1 cycle).
- Result handshake completes on an edge with out_valid & out_ready. out_valid drops the following cycle.
- If out_ready is held high, HOLD lasts exactly one cycle.
- Reset (any state, including mid-SHIFT or HOLD), asynchronously: state=IDLE, in_ready=1 after reset release, out_valid=0, busy=0, data_out=0, syndrome=0, err=0, err_cnt=0, cnt=0, shreg=0. A partially shifted word is discarded and no result is produced.
- err_cnt changes only on the HOLD-entry edge. At 16'hFFFF it holds.

## Test plan
- Reset then cw_in=64'h0, in_valid pulse, out_ready=1 -> out_valid after exactly 64 cycles; syndrome=24'h0, err=0, data_out=40'h0, err_cnt=0.
- cw_in={40'h0000000001, 24'h088211} -> syndrome=0, err=0, data_out=40'h1.
- Single-bit errors on the zero word: cw_in=64'h1 -> syndrome=24'h000001, err=1, err_cnt=1. Then cw_in=64'h1<<24 -> syndrome=24'h088211, err=1, err_cnt=2.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout. A second in_valid during HOLD is not accepted. On out_ready=1 it is accepted in IDLE on the next cycle.
- Assert rst at cnt=30 while checking 64'h1 -> all outputs return to reset values immediately, err_cnt=0, and no out_valid appears. A subsequent zero word checks clean.
- Preload err_cnt to 16'hFFFF (force or 65535 error words), then one more error word -> err_cnt stays 16'hFFFF and err=1.
